// File: rtl/joy_port_select.sv
// Joystick adapter selection, debounce, presence gating and OSD combo detection
// for the user-port DB9/MD and DB15 readers.
module joy_port_select #(
   parameter logic [15:0] DEB_CYCLES = 16'd50000,
   parameter logic [23:0] OSD_HOLD   = 24'd5000000,
   parameter int unsigned PRES_BIT   = 4
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        db9md_det,
   input  logic [15:0] md_joy1,
   input  logic [15:0] md_joy2,
   input  logic [15:0] db15_joy1,
   input  logic [15:0] db15_joy2,
   output logic        md_mode,
   output logic        p1_present,
   output logic        p2_present,
   output logic [15:0] joy1,
   output logic [15:0] joy2,
   output logic [5:0]  joy_raw,
   output logic        osd_btn
);

   // OSD combo FSM
   //   state | meaning
   //   IDLE  | combo not held, hold timer reloaded
   //   HOLD  | combo held, hold timer counting down
   //   FIRE  | combo held long enough, osd_btn asserted until release
   typedef enum logic [1:0] {IDLE, HOLD, FIRE} osd_state_t;

   localparam logic [15:0] DEB_TOP = DEB_CYCLES - 16'd1;
   localparam logic [23:0] OSD_TOP = OSD_HOLD - 24'd1;

   logic [1:0]  det_sync;
   logic [15:0] src     [2];
   logic [15:0] raw_q   [2];
   logic [15:0] deb_q   [2];
   logic [15:0] deb_nxt [2];
   logic [15:0] cnt     [2];
   logic        p1_nxt;
   logic        p2_nxt;
   logic        en;

   osd_state_t  state, state_nxt;
   logic [23:0] hcnt, hcnt_nxt;
   logic        combo;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         det_sync <= 2'b00;
         md_mode  <= 1'b0;
      end else begin
         det_sync <= {det_sync[0], db9md_det};
         if (det_sync[1]) md_mode <= 1'b1;
      end
   end

   assign src[0] = md_mode ? md_joy1 : db15_joy1;
   assign src[1] = md_mode ? md_joy2 : db15_joy2;

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         deb_nxt[i] = (cnt[i] == DEB_TOP) ? raw_q[i] : deb_q[i];
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 2; i++) begin
            raw_q[i] <= '0;
            deb_q[i] <= '0;
            cnt[i]   <= '0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            raw_q[i] <= src[i];
            deb_q[i] <= deb_nxt[i];
            if (src[i] != raw_q[i]) cnt[i] <= '0;
            else if (cnt[i] != DEB_TOP) cnt[i] <= cnt[i] + 16'd1;
         end
      end
   end

   // Presence looks at the word being debounced on this edge so the flag and
   // the debounced word land together; a duplicated P1 in MD mode never marks P2.
   assign p1_nxt = p1_present | deb_nxt[0][PRES_BIT];
   assign p2_nxt = p2_present |
                   (deb_nxt[1][PRES_BIT] & (~md_mode | ~deb_nxt[0][PRES_BIT]));
   assign en     = p1_present | p2_present;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         p1_present <= 1'b0;
         p2_present <= 1'b0;
         joy1       <= '0;
         joy2       <= '0;
      end else begin
         p1_present <= p1_nxt;
         p2_present <= p2_nxt;
         joy1       <= en ? deb_q[0] : '0;
         joy2       <= en ? deb_q[1] : '0;
      end
   end

   assign joy_raw = joy1[5:0] | joy2[5:0];
   assign combo   = joy1[10] & joy1[6];

   always_comb begin
      state_nxt = state;
      hcnt_nxt  = hcnt;
      case (state)
         IDLE: begin
            hcnt_nxt = OSD_TOP;
            if (combo) state_nxt = HOLD;
         end
         HOLD: begin
            if (!combo) state_nxt = IDLE;
            else if (hcnt == 24'd0) state_nxt = FIRE;
            else hcnt_nxt = hcnt - 24'd1;
         end
         FIRE: begin
            if (!combo) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         hcnt    <= '0;
         osd_btn <= 1'b0;
      end else begin
         state   <= state_nxt;
         hcnt    <= hcnt_nxt;
         osd_btn <= (state_nxt == FIRE);
      end
   end

endmodule
